nibble_add_seq: RTL and testbench

- Sequencer that sits directly upstream of the registered 4-bit adder stage and also consumes that stage's output.
- Adds two WIDTH-bit operands by issuing them to the 4-bit adder one nibble at a time, LSB nibble first.
- Chains each nibble's carry-out into the next nibble's carry-in.
- Assembles the full sum and reports completion with a one-cycle done pulse.

---
 rtl/nibble_add_seq.sv | 129 ++++++++++++
 tb/tb_nibble_add_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: issues a WIDTH-bit add to a registered 4-bit adder,
// one nibble at a time (LSB first), chaining carries and assembling the sum.
module nibble_add_seq #(
   parameter int WIDTH     = 16,
   parameter int ADDER_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic [3:0]       adder_a,
   output logic [3:0]       adder_b,
   output logic             adder_cin,
   input  logic [3:0]       adder_sum,
   input  logic             adder_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST    = IW'(NIB - 1);
   localparam logic [2:0]    CNT_END = 3'(ADDER_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    idx_d;
   logic [2:0]       cnt_q;
   logic [3:0]       adder_a_q;
   logic [3:0]       adder_b_q;
   logic             adder_cin_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;

   // Index of the nibble that follows the one currently in the adder.
   always_comb begin
      idx_d = idx_q + 1'b1;
   end

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         adder_a_q   <= '0;
         adder_b_q   <= '0;
         adder_cin_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q         <= op_a;
                  b_q         <= op_b;
                  idx_q       <= '0;
                  adder_a_q   <= op_a[3:0];
                  adder_b_q   <= op_b[3:0];
                  adder_cin_q <= cin;
                  busy_q      <= 1'b1;
                  result_q    <= '0;
                  cout_q      <= 1'b0;
                  ovf_q       <= 1'b0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == CNT_END) begin
                  result_q[{idx_q, 2'b00} +: 4] <= adder_sum;
                  if (idx_q != LAST) begin
                     idx_q       <= idx_d;
                     adder_a_q   <= a_q[{idx_d, 2'b00} +: 4];
                     adder_b_q   <= b_q[{idx_d, 2'b00} +: 4];
                     adder_cin_q <= adder_cout;
                     state_q     <= S_ISSUE;
                  end else begin
                     cout_q  <= adder_cout;
                     ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (adder_sum[3] != a_q[WIDTH-1]);
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign adder_a   = adder_a_q;
   assign adder_b   = adder_b_q;
   assign adder_cin = adder_cin_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed vectors for nibble_add_seq with
// registered 4-bit adder models (latency 1 and latency 3 instances).
module tb_nibble_add_seq;

   logic        clk = 1'b0;
   logic        rst;

   // Instance 1: ADDER_LAT = 1
   logic        start1;
   logic [15:0] op_a1, op_b1;
   logic        cin1;
   logic [3:0]  aa1, ab1;
   logic        acin1;
   logic [4:0]  p1;
   logic        busy1, done1, cout1, ovf1;
   logic [15:0] res1;

   // Instance 3: ADDER_LAT = 3
   logic        start3;
   logic [15:0] op_a3, op_b3;
   logic        cin3;
   logic [3:0]  aa3, ab3;
   logic        acin3;
   logic [4:0]  p3a, p3b, p3c;
   logic        busy3, done3, cout3, ovf3;
   logic [15:0] res3;

   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   // Adder models: operands registered at an edge, pipelined by latency.
   always_ff @(posedge clk) begin
      p1  <= {1'b0, aa1} + {1'b0, ab1} + {4'b0, acin1};
      p3a <= {1'b0, aa3} + {1'b0, ab3} + {4'b0, acin3};
      p3b <= p3a;
      p3c <= p3b;
   end

   nibble_add_seq #(.WIDTH(16), .ADDER_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .op_a(op_a1), .op_b(op_b1), .cin(cin1),
      .adder_a(aa1), .adder_b(ab1), .adder_cin(acin1),
      .adder_sum(p1[3:0]), .adder_cout(p1[4]),
      .busy(busy1), .done(done1), .result(res1),
      .cout(cout1), .ovf(ovf1)
   );

   nibble_add_seq #(.WIDTH(16), .ADDER_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3),
      .op_a(op_a3), .op_b(op_b3), .cin(cin3),
      .adder_a(aa3), .adder_b(ab3), .adder_cin(acin3),
      .adder_sum(p3c[3:0]), .adder_cout(p3c[4]),
      .busy(busy3), .done(done3), .result(res3),
      .cout(cout3), .ovf(ovf3)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] r;
      logic        co;
      logic        ov;
      logic [3:0]  cins;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drive a start pulse; returns #1 after the accepting edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                           input logic c);
      op_a1  = a;
      op_b1  = b;
      cin1   = c;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
   endtask

   // Count edges until done (bounded); record busy and per-nibble cin.
   task automatic wait_done(input int n0, output int lat,
                            output int busy_bad, output logic [3:0] cins);
      busy_bad = 0;
      cins     = 4'b0;
      lat      = 64;
      if (n0 == 0) begin
         cins[0] = acin1;
         if (!busy1) busy_bad++;
      end
      for (int n = n0 + 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         if (done1) begin
            lat = n;
            break;
         end
         if (!busy1) busy_bad++;
         if (n % 2 == 0 && n < 8) cins[n/2] = acin1;
      end
   endtask

   initial begin
      int         lat;
      int         bb;
      int         dcnt;
      logic [3:0] cins;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
      vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
      vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
      vecs[5] = '{16'h8000, 16'h7FFF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 4'b0000};
      vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0110};

      rst    = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      op_a1  = '0;
      op_b1  = '0;
      cin1   = 1'b0;
      op_a3  = '0;
      op_b3  = '0;
      cin3   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy1}, 0);
      chk("rst_done", {31'b0, done1}, 0);
      chk("rst_result", {16'b0, res1}, 0);
      chk("rst_flags", {29'b0, cout1, ovf1, acin1}, 0);
      chk("rst_adder", {24'b0, aa1, ab1}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         start_op(vecs[i].a, vecs[i].b, vecs[i].c);
         wait_done(0, lat, bb, cins);
         chk($sformatf("v%0d_latency", i), lat, 8);
         chk($sformatf("v%0d_busy", i), bb, 0);
         chk($sformatf("v%0d_result", i), {16'b0, res1}, {16'b0, vecs[i].r});
         chk($sformatf("v%0d_cout", i), {31'b0, cout1}, {31'b0, vecs[i].co});
         chk($sformatf("v%0d_ovf", i), {31'b0, ovf1}, {31'b0, vecs[i].ov});
         chk($sformatf("v%0d_cins", i), {28'b0, cins}, {28'b0, vecs[i].cins});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", i), {31'b0, done1}, 0);
         chk($sformatf("v%0d_hold", i), {16'b0, res1}, {16'b0, vecs[i].r});
      end

      // Start while busy is ignored
      @(negedge clk);
      start_op(16'h1234, 16'h4321, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      op_a1  = 16'hFFFF;
      op_b1  = 16'hFFFF;
      cin1   = 1'b1;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      wait_done(4, lat, bb, cins);
      chk("busy_start_latency", lat, 8);
      chk("busy_start_result", {16'b0, res1}, 32'h5555);
      chk("busy_start_cout", {31'b0, cout1}, 0);

      // Start in the done cycle is accepted back-to-back
      chk("done_cycle_busy", {31'b0, busy1}, 0);
      start_op(16'h0F0F, 16'h0101, 1'b0);
      chk("b2b_partial_clear", {16'b0, res1}, 0);
      wait_done(0, lat, bb, cins);
      chk("b2b_latency", lat, 8);
      chk("b2b_busy", bb, 0);
      chk("b2b_result", {16'b0, res1}, 32'h1010);
      chk("b2b_flags", {30'b0, cout1, ovf1}, 0);

      // Reset mid-operation discards it
      @(negedge clk);
      start_op(16'h1234, 16'h4321, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, busy1}, 0);
      chk("midrst_result", {16'b0, res1}, 0);
      chk("midrst_adder", {23'b0, aa1, ab1, acin1}, 0);
      @(negedge clk);
      rst  = 1'b0;
      dcnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (done1 || busy1) dcnt++;
      end
      chk("midrst_no_done", dcnt, 0);
      @(negedge clk);
      start_op(16'h00FF, 16'h0001, 1'b0);
      wait_done(0, lat, bb, cins);
      chk("postrst_latency", lat, 8);
      chk("postrst_result", {16'b0, res1}, 32'h0100);

      // ADDER_LAT = 3 instance
      @(negedge clk);
      op_a3  = 16'h1234;
      op_b3  = 16'h4321;
      cin3   = 1'b0;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      lat    = 64;
      bb     = 0;
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         if (done3) begin
            lat = n;
            break;
         end
         if (!busy3) bb++;
      end
      chk("lat3_latency", lat, 16);
      chk("lat3_busy", bb, 0);
      chk("lat3_result", {16'b0, res3}, 32'h5555);
      chk("lat3_flags", {30'b0, cout3, ovf3}, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
